// File: rtl/fabric_cfg_pkg.sv
// Shared definitions for the Wishbone configuration streamer: register offsets,
// STATUS/CTRL bit positions and the shift-engine state encoding.
package fabric_cfg_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_COLSEL = 8'h04;
    localparam logic [7:0] REG_DATA   = 8'h08;
    localparam logic [7:0] REG_STATUS = 8'h0C;
    localparam logic [7:0] REG_RDBK   = 8'h10;

    localparam int unsigned CTRL_CEN_BIT = 0;
    localparam int unsigned CTRL_SET_BIT = 1;

    localparam int unsigned STAT_BUSY_BIT  = 0;
    localparam int unsigned STAT_EMPTY_BIT = 1;
    localparam int unsigned STAT_FULL_BIT  = 2;
    localparam int unsigned STAT_SETP_BIT  = 3;
    localparam int unsigned STAT_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_SET   = 2'd2
    } shift_state_e;

endpackage

// File: rtl/cfg_word_fifo.sv
// Synchronous FIFO holding {column, word} entries; push and pop may coincide,
// including when full.
module cfg_word_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/wb_bitstream_shifter.sv
// Wishbone slave that streams buffered 32-bit words LSB-first into per-column
// configuration chains. Optional chain readback: WB_BITSTREAM_READBACK_EN.
module wb_bitstream_shifter
    import fabric_cfg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned NUM_COLS   = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned COL_W      = $clog2(NUM_COLS)
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_data_i,
    input  logic [31:0]         wbs_addr_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_data_o,
    output logic                cen,
    output logic [NUM_COLS-1:0] cfg_data_out,
    output logic [NUM_COLS-1:0] shift_out,
    output logic [NUM_COLS-1:0] set_out,
    input  logic [NUM_COLS-1:0] cfg_data_in
);
    localparam int unsigned FW = WORD_W + COL_W;

    logic                        ack_q, ack_d;
    logic [31:0]                 rdata_q, rdata_d, rd_mux, status, rdbk_word;
    logic                        cen_q, cen_d;
    logic [COL_W-1:0]            colsel_q, colsel_d;
    logic                        set_pending_q, set_pending_d;
    logic                        push_q, push_d;
    logic [FW-1:0]               push_word_q, push_word_d;
    shift_state_e                state_q, state_d;
    logic [WORD_W-1:0]           sr_q, sr_d;
    logic [4:0]                  bitcnt_q, bitcnt_d;
    logic [COL_W-1:0]            col_q, col_d;
    logic [NUM_COLS-1:0]         dirty_q, dirty_d;

    logic [7:0]                  off;
    logic                        req, data_wr, accept, set_req, clear_set, load;
    logic                        fifo_pop, fifo_full, fifo_empty;
    logic [FW-1:0]               fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    cfg_word_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (push_q),
        .din_i   (push_word_q),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        status                            = '0;
        status[STAT_BUSY_BIT]             = (state_q != ST_IDLE);
        status[STAT_EMPTY_BIT]            = fifo_empty;
        status[STAT_FULL_BIT]             = fifo_full;
        status[STAT_SETP_BIT]             = set_pending_q;
        status[STAT_COUNT_LSB +: 8]       = 8'(fifo_count);
    end

    // Pushes are issued the cycle the ack is visible; the full-check is exact
    // because ack_q blocks a new accept while a push is still in flight.
    always_comb begin
        off     = wbs_addr_i[7:0];
        req     = wbs_stb_i && wbs_cyc_i && (wbs_addr_i[31:8] == BASE_ADDR[31:8]);
        data_wr = wbs_we_i && (off == REG_DATA);
        accept  = req && !ack_q && !(data_wr && fifo_full && !fifo_pop);

        ack_d       = accept;
        push_d      = accept && data_wr && (wbs_sel_i == 4'hF);
        push_word_d = {colsel_q, wbs_data_i};

        cen_d   = cen_q;
        set_req = 1'b0;
        if (accept && wbs_we_i && (off == REG_CTRL) && wbs_sel_i[0]) begin
            cen_d   = wbs_data_i[CTRL_CEN_BIT];
            set_req = wbs_data_i[CTRL_SET_BIT];
        end
        set_pending_d = (set_pending_q && !clear_set) || set_req;

        colsel_d = colsel_q;
        if (accept && wbs_we_i && (off == REG_COLSEL)) begin
            for (int unsigned i = 0; i < COL_W; i++) begin
                if (wbs_sel_i[i/8]) colsel_d[i] = wbs_data_i[i];
            end
        end

        case (off)
            REG_CTRL:   rd_mux = 32'(cen_q);
            REG_COLSEL: rd_mux = 32'(colsel_q);
            REG_STATUS: rd_mux = status;
            REG_RDBK:   rd_mux = rdbk_word;
            default:    rd_mux = '0;
        endcase
        rdata_d = (accept && !wbs_we_i) ? rd_mux : '0;
    end

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        bitcnt_d     = bitcnt_q;
        col_d        = col_q;
        dirty_d      = dirty_q;
        fifo_pop     = 1'b0;
        clear_set    = 1'b0;
        load         = 1'b0;
        cfg_data_out = '0;
        shift_out    = '0;
        set_out      = '0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty)        load    = 1'b1;
                else if (set_pending_q) state_d = ST_SET;
            end
            ST_SHIFT: begin
                cfg_data_out[col_q] = sr_q[0];
                shift_out[col_q]    = 1'b1;
                sr_d                = {1'b0, sr_q[WORD_W-1:1]};
                bitcnt_d            = bitcnt_q + 5'd1;
                if (bitcnt_q == 5'd31) begin
                    if (!fifo_empty) load    = 1'b1;
                    else             state_d = ST_IDLE;
                end
            end
            ST_SET: begin
                set_out   = dirty_q;
                dirty_d   = '0;
                clear_set = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            fifo_pop        = 1'b1;
            sr_d            = fifo_dout[WORD_W-1:0];
            col_d           = fifo_dout[FW-1:WORD_W];
            bitcnt_d        = '0;
            dirty_d[col_d]  = 1'b1;
            state_d         = ST_SHIFT;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q         <= '0;
            rdata_q       <= '0;
            cen_q         <= '0;
            colsel_q      <= '0;
            set_pending_q <= '0;
            push_q        <= '0;
            push_word_q   <= '0;
            state_q       <= ST_IDLE;
            sr_q          <= '0;
            bitcnt_q      <= '0;
            col_q         <= '0;
            dirty_q       <= '0;
        end else begin
            ack_q         <= ack_d;
            rdata_q       <= rdata_d;
            cen_q         <= cen_d;
            colsel_q      <= colsel_d;
            set_pending_q <= set_pending_d;
            push_q        <= push_d;
            push_word_q   <= push_word_d;
            state_q       <= state_d;
            sr_q          <= sr_d;
            bitcnt_q      <= bitcnt_d;
            col_q         <= col_d;
            dirty_q       <= dirty_d;
        end
    end

`ifdef WB_BITSTREAM_READBACK_EN
    logic [WORD_W-1:0] cap_q, rdbk_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cap_q  <= '0;
            rdbk_q <= '0;
        end else if (state_q == ST_SHIFT) begin
            cap_q <= {cfg_data_in[col_q], cap_q[WORD_W-1:1]};
            if (bitcnt_q == 5'd31) rdbk_q <= {cfg_data_in[col_q], cap_q[WORD_W-1:1]};
        end
    end

    assign rdbk_word = rdbk_q;
`else
    logic unused_cfg_in;
    assign unused_cfg_in = ^cfg_data_in;
    assign rdbk_word     = '0;
`endif

    assign wbs_ack_o  = ack_q;
    assign wbs_data_o = rdata_q;
    assign cen        = cen_q;

endmodule

// File: tb/tb_wb_bitstream_shifter.sv
// Directed bench for wb_bitstream_shifter: register table plus streaming,
// stall, set, reset and readback sequences.
module tb_wb_bitstream_shifter;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          TMO  = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] wdata, addr;
    logic        ack;
    logic [31:0] rdata;
    logic        cen_o;
    logic [3:0]  cfg_out, shift_o, set_o, cfg_in;

    int n_cmp = 0;
    int n_err = 0;

    wb_bitstream_shifter #(
        .BASE_ADDR  (BASE),
        .NUM_COLS   (4),
        .FIFO_DEPTH (4)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wbs_stb_i    (stb),
        .wbs_cyc_i    (cyc),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_data_i   (wdata),
        .wbs_addr_i   (addr),
        .wbs_ack_o    (ack),
        .wbs_data_o   (rdata),
        .cen          (cen_o),
        .cfg_data_out (cfg_out),
        .shift_out    (shift_o),
        .set_out      (set_o),
        .cfg_data_in  (cfg_in)
    );

    always #5 clk = ~clk;

    // 32-flop scan chain per column, returning its tail as cfg_data_in
    logic [31:0] chain_q [4] = '{default: '0};
    always @(posedge clk)
        for (int c = 0; c < 4; c++)
            if (shift_o[c]) chain_q[c] <= {chain_q[c][30:0], cfg_out[c]};
    always_comb
        for (int c = 0; c < 4; c++) cfg_in[c] = chain_q[c][31];

    int         cyc_cnt = 0, shift_total, run, max_run, stray, set_cycles, set_cyc, last_shift_cyc;
    logic [3:0] last_set;
    bit         bitq[$];
    int         colq[$];

    always @(negedge clk) begin
        cyc_cnt++;
        if (shift_o != 4'b0) begin
            shift_total++;
            run++;
            if (run > max_run) max_run = run;
            last_shift_cyc = cyc_cnt;
            if ($countones(shift_o) != 1) stray++;
            for (int c = 0; c < 4; c++)
                if (shift_o[c]) begin
                    bitq.push_back(cfg_out[c]);
                    colq.push_back(c);
                end
        end else begin
            run = 0;
        end
        if ((cfg_out & ~shift_o) != 4'b0) stray++;
        if (set_o != 4'b0) begin
            set_cycles++;
            last_set = set_o;
            set_cyc  = cyc_cnt;
        end
    end

    task automatic mon_clear();
        shift_total = 0; run = 0; max_run = 0; stray = 0;
        set_cycles = 0; set_cyc = 0; last_shift_cyc = 0; last_set = '0;
        bitq.delete();
        colq.delete();
    endtask

    function automatic logic [31:0] word_at(input int k);
        logic [31:0] w = '0;
        for (int i = 0; i < 32; i++)
            if (k*32 + i < bitq.size()) w[i] = bitq[k*32 + i];
        return w;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] rd,
                           output int waited, output bit ok);
        stb = 1'b1; cyc = 1'b1; we = w; sel = s; addr = a; wdata = d;
        waited = 0; ok = 1'b0; rd = '0;
        while (!ok && waited < TMO) begin
            @(posedge clk); #1;
            waited++;
            if (ack) begin
                ok = 1'b1;
                rd = rdata;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wb_wr(input string nm, input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd; int w; bit ok;
        wb_xfer(BASE | 32'(off), 1'b1, s, d, rd, w, ok);
        check({nm, " ack"}, 32'(ok), 32'd1);
    endtask

    task automatic wb_rd(input string nm, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] rd; int w; bit ok;
        wb_xfer(BASE | 32'(off), 1'b0, 4'hF, 32'h0, rd, w, ok);
        check({nm, " ack"}, 32'(ok), 32'd1);
        check(nm, rd, exp);
    endtask

    typedef struct {
        string       name;
        logic [7:0]  off;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [31:0] rd, w6 [6];
        int          waited, acks;
        bit          ok;

        tbl[0]  = '{"rst_status",  8'h0C, 1'b0, 4'hF, 32'h0,         32'h0000_0002};
        tbl[1]  = '{"rst_ctrl",    8'h00, 1'b0, 4'hF, 32'h0,         32'h0};
        tbl[2]  = '{"rst_colsel",  8'h04, 1'b0, 4'hF, 32'h0,         32'h0};
        tbl[3]  = '{"wr_colsel2",  8'h04, 1'b1, 4'hF, 32'h2,         32'h0};
        tbl[4]  = '{"rd_colsel2",  8'h04, 1'b0, 4'hF, 32'h0,         32'h2};
        tbl[5]  = '{"wr_colsel_m", 8'h04, 1'b1, 4'hE, 32'h3,         32'h0};
        tbl[6]  = '{"rd_colsel_m", 8'h04, 1'b0, 4'hF, 32'h0,         32'h2};
        tbl[7]  = '{"wr_ctrl1",    8'h00, 1'b1, 4'hF, 32'h1,         32'h0};
        tbl[8]  = '{"rd_ctrl1",    8'h00, 1'b0, 4'hF, 32'h0,         32'h1};
        tbl[9]  = '{"wr_ctrl0",    8'h00, 1'b1, 4'hF, 32'h0,         32'h0};
        tbl[10] = '{"rd_data",     8'h08, 1'b0, 4'hF, 32'h0,         32'h0};
        tbl[11] = '{"rd_rdbk",     8'h10, 1'b0, 4'hF, 32'h0,         32'h0};
        tbl[12] = '{"wr_hole",     8'h14, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0};
        tbl[13] = '{"rd_hole",     8'h14, 1'b0, 4'hF, 32'h0,         32'h0};
        tbl[14] = '{"rd_status2",  8'h0C, 1'b0, 4'hF, 32'h0,         32'h0000_0002};

        stb = 0; cyc = 0; we = 0; sel = 0; wdata = 0; addr = 0;
        mon_clear();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",   32'(ack),     32'h0);
        check("rst_rdata", rdata,        32'h0);
        check("rst_cen",   32'(cen_o),   32'h0);
        check("rst_cfg",   32'(cfg_out), 32'h0);
        check("rst_shift", 32'(shift_o), 32'h0);
        check("rst_set",   32'(set_o),   32'h0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            wb_xfer(BASE | 32'(tbl[i].off), tbl[i].we, tbl[i].sel, tbl[i].wdata, rd, waited, ok);
            check({tbl[i].name, " ack"}, 32'(ok), 32'd1);
            check(tbl[i].name, rd, tbl[i].exp);
        end

        // Foreign window: never acknowledged
        stb = 1'b1; cyc = 1'b1; we = 1'b0; sel = 4'hF; addr = 32'h3000_010C;
        acks = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        stb = 1'b0; cyc = 1'b0;
        check("foreign_no_ack", 32'(acks), 32'd0);

        // Single word to column 2: first strobe two cycles after ack
        mon_clear();
        wb_wr("data_a5", 8'h08, 32'hA5A5_0F0F, 4'hF);
        @(posedge clk); #1;
        check("shift_n1", 32'(shift_o), 32'h0);
        @(posedge clk); #1;
        check("shift_n2", 32'(shift_o), 32'h4);
        check("cfg_n2",   32'(cfg_out), 32'h4);
        repeat (40) @(posedge clk);
        #1;
        check("w1_total", 32'(shift_total), 32'd32);
        check("w1_run",   32'(max_run),     32'd32);
        check("w1_word",  word_at(0),       32'hA5A5_0F0F);
        check("w1_col",   32'(colq[0]),     32'd2);
        check("w1_stray", 32'(stray),       32'd0);

        // Six back-to-back words: FIFO fills, the last write stalls
        w6 = '{32'h0000_0001, 32'h8000_0000, 32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_0000, 32'h0F0F_A5A5};
        wb_wr("colsel1", 8'h04, 32'h1, 4'hF);
        mon_clear();
        for (int i = 0; i < 5; i++) wb_wr("burst", 8'h08, w6[i], 4'hF);
        wb_rd("status_full", 8'h0C, 32'h0000_0405);
        wb_xfer(BASE | 32'h08, 1'b1, 4'hF, w6[5], rd, waited, ok);
        check("stall_ack", 32'(ok), 32'd1);
        check("stall_len", 32'(waited >= 20 && waited <= 40), 32'd1);
        repeat (200) @(posedge clk);
        #1;
        check("burst_total", 32'(shift_total), 32'd192);
        check("burst_run",   32'(max_run),     32'd192);
        for (int k = 0; k < 6; k++) check($sformatf("burst_word%0d", k), word_at(k), w6[k]);
        check("burst_col", 32'(colq[191]), 32'd1);
        check("burst_stray", 32'(stray), 32'd0);

        // Columns 1 and 2 are dirty; a set while idle fires at once
        mon_clear();
        wb_wr("set_idle", 8'h00, 32'h2, 4'hF);
        repeat (10) @(posedge clk);
        #1;
        check("set_idle_n",    32'(set_cycles), 32'd1);
        check("set_idle_mask", 32'(last_set),   32'h6);

        // Set requested while busy waits for the drain; duplicates absorbed
        mon_clear();
        wb_wr("colsel0", 8'h04, 32'h0, 4'hF);
        wb_wr("data_c0", 8'h08, 32'hCAFE_0001, 4'hF);
        wb_wr("colsel3", 8'h04, 32'h3, 4'hF);
        wb_wr("data_c3", 8'h08, 32'h0000_FACE, 4'hF);
        wb_wr("ctrl3_a", 8'h00, 32'h3, 4'hF);
        wb_wr("ctrl3_b", 8'h00, 32'h3, 4'hF);
        wb_rd("status_setp", 8'h0C, 32'h0000_0109);
        check("set_early", 32'(set_cycles), 32'd0);
        repeat (100) @(posedge clk);
        #1;
        check("set_busy_n",    32'(set_cycles), 32'd1);
        check("set_busy_mask", 32'(last_set),   32'h9);
        check("set_after",     32'(set_cyc > last_shift_cyc && set_cyc - last_shift_cyc <= 3), 32'd1);
        check("set_words",     word_at(1),      32'h0000_FACE);
        check("set_cols",      32'(colq[0] * 4 + colq[32]), 32'd3);
        check("cen_on",        32'(cen_o),      32'h1);
        wb_rd("ctrl_rd", 8'h00, 32'h1);
        wb_rd("status_idle", 8'h0C, 32'h0000_0002);
        wb_wr("ctrl_lane", 8'h00, 32'h0, 4'hE);
        check("cen_lane", 32'(cen_o), 32'h1);
        wb_wr("ctrl_off", 8'h00, 32'h0, 4'hF);
        check("cen_off", 32'(cen_o), 32'h0);

        // Reset at bit 10 of a word with a second word queued
        wb_wr("colsel1b", 8'h04, 32'h1, 4'hF);
        wb_wr("data_r0", 8'h08, 32'h0000_0400, 4'hF);
        wb_wr("data_r1", 8'h08, 32'hFFFF_FFFF, 4'hF);
        repeat (10) @(posedge clk);
        #1;
        check("mid_shift",   32'(shift_o), 32'h2);
        check("mid_bit10",   32'(cfg_out), 32'h2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_shift", 32'(shift_o), 32'h0);
        check("rst_mid_cfg",   32'(cfg_out), 32'h0);
        check("rst_mid_set",   32'(set_o),   32'h0);
        mon_clear();
        wb_rd("rst_mid_status", 8'h0C, 32'h0000_0002);
        wb_wr("set_clean", 8'h00, 32'h2, 4'hF);
        repeat (10) @(posedge clk);
        #1;
        check("clean_set",   32'(set_cycles),  32'd0);
        check("clean_shift", 32'(shift_total), 32'd0);

        // Partial-lane DATA write is acknowledged but not queued
        wb_wr("data_partial", 8'h08, 32'h1111_1111, 4'h3);
        repeat (5) @(posedge clk);
        #1;
        check("partial_shift", 32'(shift_total), 32'd0);
        wb_rd("partial_status", 8'h0C, 32'h0000_0002);

        // Readback through the modelled 32-bit chain
        wb_wr("colsel0b", 8'h04, 32'h0, 4'hF);
        wb_wr("rb_w0", 8'h08, 32'h1234_5678, 4'hF);
        wb_wr("rb_w1", 8'h08, 32'h1234_5678, 4'hF);
        repeat (80) @(posedge clk);
        #1;
`ifdef WB_BITSTREAM_READBACK_EN
        wb_rd("rdbk", 8'h10, 32'h1234_5678);
`else
        wb_rd("rdbk", 8'h10, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
